// File: rtl/dcache_port_arbiter_if.sv
// Handshake bundle between the LSQ, the D-cache and the port arbiter.
// master: arbiter side; slave: queue/cache side.
interface dcache_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 3
);
  logic                  ld_req_valid;
  logic [ADDR_WIDTH-1:0] ld_req_addr;
  logic [IDX_WIDTH-1:0]  ld_req_idx;
  logic                  ld_req_ready;
  logic                  st_req_valid;
  logic [ADDR_WIDTH-1:0] st_req_addr;
  logic [DATA_WIDTH-1:0] st_req_data;
  logic [IDX_WIDTH-1:0]  st_req_idx;
  logic                  st_req_ready;
  logic                  flush;
  logic                  dc_miss;
  logic                  dc_done;
  logic                  dc_req_valid;
  logic                  dc_req_write;
  logic [ADDR_WIDTH-1:0] dc_req_addr;
  logic [DATA_WIDTH-1:0] dc_req_data;
  logic [IDX_WIDTH-1:0]  dc_req_idx;
  logic                  ld_done_valid;
  logic [IDX_WIDTH-1:0]  ld_done_idx;
  logic                  st_done_valid;
  logic [IDX_WIDTH-1:0]  st_done_idx;
  logic                  busy;

  modport master (
    input  ld_req_valid, ld_req_addr, ld_req_idx,
    input  st_req_valid, st_req_addr, st_req_data,
    input  st_req_idx, flush, dc_miss, dc_done,
    output ld_req_ready, st_req_ready,
    output dc_req_valid, dc_req_write, dc_req_addr,
    output dc_req_data, dc_req_idx,
    output ld_done_valid, ld_done_idx,
    output st_done_valid, st_done_idx, busy
  );

  modport slave (
    output ld_req_valid, ld_req_addr, ld_req_idx,
    output st_req_valid, st_req_addr, st_req_data,
    output st_req_idx, flush, dc_miss, dc_done,
    input  ld_req_ready, st_req_ready,
    input  dc_req_valid, dc_req_write, dc_req_addr,
    input  dc_req_data, dc_req_idx,
    input  ld_done_valid, ld_done_idx,
    input  st_done_valid, st_done_idx, busy
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Single-port D-cache sequencer: store-drain vs load-dispatch arbiter.
// Ports: clk, rst_n (async low), bus (master modport of the _if bundle).
module dcache_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_WIDTH    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  dcache_port_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, MISS_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  squash_q, squash_d;

  logic can_accept, st_pri, grant_st, grant_ld;
  logic ld_done, st_done;

  // Flush removes the load from contention so a
  // starved load cannot block a store that cycle.
  always_comb begin
    st_pri   = (starve_q < SW'(STARVE_LIMIT)) ||
               !bus.ld_req_valid || bus.flush;
    grant_st = can_accept && bus.st_req_valid && st_pri;
    grant_ld = can_accept && bus.ld_req_valid &&
               !bus.flush && !grant_st;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    squash_d   = squash_q;
    can_accept = 1'b0;
    ld_done    = 1'b0;
    st_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        can_accept = 1'b1;
      end
      ISSUE: begin
        can_accept = !bus.dc_miss;
        if (!write_q && bus.flush) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (bus.dc_miss) begin
          state_d = MISS_WAIT;
        end else begin
          ld_done = !write_q;
          st_done = write_q;
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      MISS_WAIT: begin
        if (bus.dc_done) begin
          ld_done  = !write_q && !squash_q && !bus.flush;
          st_done  = write_q;
          state_d  = IDLE;
          valid_d  = 1'b0;
          squash_d = 1'b0;
        end else if (!write_q && bus.flush) begin
          squash_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (grant_st) begin
      state_d = ISSUE;
      valid_d = 1'b1;
      write_d = 1'b1;
      addr_d  = bus.st_req_addr;
      data_d  = bus.st_req_data;
      idx_d   = bus.st_req_idx;
    end else if (grant_ld) begin
      state_d = ISSUE;
      valid_d = 1'b1;
      write_d = 1'b0;
      addr_d  = bus.ld_req_addr;
      data_d  = '0;
      idx_d   = bus.ld_req_idx;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.ld_req_valid || grant_ld)
      starve_d = '0;
    else if (starve_q < SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      starve_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
      squash_q <= squash_d;
    end
  end

  assign bus.ld_req_ready  = grant_ld;
  assign bus.st_req_ready  = grant_st;
  assign bus.dc_req_valid  = valid_q;
  assign bus.dc_req_write  = write_q;
  assign bus.dc_req_addr   = addr_q;
  assign bus.dc_req_data   = data_q;
  assign bus.dc_req_idx    = idx_q;
  assign bus.ld_done_valid = ld_done;
  assign bus.ld_done_idx   = idx_q;
  assign bus.st_done_valid = st_done;
  assign bus.st_done_idx   = idx_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter.
// Completions are queued at stimulus time and popped on done pulses.
module tb_dcache_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_port_arbiter_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .IDX_WIDTH(3)
  ) bus ();

  dcache_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .IDX_WIDTH(3), .STARVE_LIMIT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         wr;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic push(input bit wr, input logic [2:0] idx);
    exp_t e;
    e.wr  = wr;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.ld_done_valid) begin
        n_done++;
        if (exp_q.size() == 0)
          chk("ld_done_unexp", bus.ld_done_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("ld_done_kind", e.wr, 0);
          chk("ld_done_idx", bus.ld_done_idx, e.idx);
        end
      end
      if (bus.st_done_valid) begin
        n_done++;
        if (exp_q.size() == 0)
          chk("st_done_unexp", bus.st_done_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("st_done_kind", e.wr, 1);
          chk("st_done_idx", bus.st_done_idx, e.idx);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.ld_req_valid = 1'b0;
    bus.ld_req_addr  = '0;
    bus.ld_req_idx   = '0;
    bus.st_req_valid = 1'b0;
    bus.st_req_addr  = '0;
    bus.st_req_data  = '0;
    bus.st_req_idx   = '0;
    bus.flush        = 1'b0;
    bus.dc_miss      = 1'b0;
    bus.dc_done      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int want, input bit use_st,
                        input bit use_ld, input bit chk_v);
    int got = 0;
    int sn = 0;
    int ln = 0;
    int cyc = 0;
    bit as, al;
    while (got < want && cyc < 100) begin
      step();
      bus.st_req_valid = use_st;
      bus.st_req_idx   = sn[2:0];
      bus.st_req_addr  = 32'h1000 + 32'(sn * 4);
      bus.st_req_data  = 32'hA000 + 32'(sn);
      bus.ld_req_valid = use_ld;
      bus.ld_req_idx   = ln[2:0];
      bus.ld_req_addr  = 32'h2000 + 32'(ln * 4);
      @(negedge clk);
      if (chk_v && got > 0)
        chk("stream_dc_valid", bus.dc_req_valid, 1);
      as = bus.st_req_valid && bus.st_req_ready;
      al = bus.ld_req_valid && bus.ld_req_ready;
      if (as) sn++;
      if (al) ln++;
      got += int'(as) + int'(al);
      cyc++;
    end
    if (got < want) chk("stream_timeout", got, want);
    step();
    bus.st_req_valid = 1'b0;
    bus.ld_req_valid = 1'b0;
    @(negedge clk);
    if (chk_v) chk("stream_last_valid", bus.dc_req_valid, 1);
  endtask

  initial begin
    int d0;
    idle_inputs();
    #2;
    chk("rst_dc_valid", bus.dc_req_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ld_done", bus.ld_done_valid, 0);
    chk("rst_st_done", bus.st_done_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // load hit
    step();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h100;
    bus.ld_req_idx   = 3'd2;
    @(negedge clk);
    chk("t2_ld_ready", bus.ld_req_ready, 1);
    push(1'b0, 3'd2);
    step();
    bus.ld_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_dc_valid", bus.dc_req_valid, 1);
    chk("t2_dc_addr", bus.dc_req_addr, 32'h100);
    chk("t2_dc_write", bus.dc_req_write, 0);
    chk("t2_dc_idx", bus.dc_req_idx, 2);
    chk("t2_ld_done", bus.ld_done_valid, 1);
    @(negedge clk);
    chk("t2_idle_valid", bus.dc_req_valid, 0);
    chk("t2_idle_busy", bus.busy, 0);

    // store miss, refill 6 cycles later
    step();
    bus.st_req_valid = 1'b1;
    bus.st_req_addr  = 32'h200;
    bus.st_req_data  = 32'hDEADBEEF;
    bus.st_req_idx   = 3'd5;
    @(negedge clk);
    chk("t3_st_ready", bus.st_req_ready, 1);
    push(1'b1, 3'd5);
    step();
    bus.st_req_valid = 1'b0;
    bus.dc_miss      = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) bus.dc_miss = 1'b0;
      if (c == 7) bus.dc_done = 1'b1;
      @(negedge clk);
      chk("t3_valid", bus.dc_req_valid, 1);
      chk("t3_addr", bus.dc_req_addr, 32'h200);
      chk("t3_data", bus.dc_req_data, 32'hDEADBEEF);
      chk("t3_idx", bus.dc_req_idx, 5);
      chk("t3_write", bus.dc_req_write, 1);
      chk("t3_st_done", bus.st_done_valid, (c == 7) ? 1 : 0);
      if (c < 7) step();
    end
    step();
    bus.dc_done = 1'b0;
    @(negedge clk);
    chk("t3_busy_end", bus.busy, 0);
    chk("t3_valid_end", bus.dc_req_valid, 0);

    // starvation: S,S,S,S,L,S,S,S,S,L
    push(1, 0); push(1, 1); push(1, 2); push(1, 3);
    push(0, 0);
    push(1, 4); push(1, 5); push(1, 6); push(1, 7);
    push(0, 1);
    d0 = n_done;
    stream(10, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t4_done_count", n_done - d0, 10);
    chk("t4_sb_empty", exp_q.size(), 0);

    // load miss then flush while waiting
    step();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h300;
    bus.ld_req_idx   = 3'd4;
    @(negedge clk);
    chk("t5_ld_ready", bus.ld_req_ready, 1);
    step();
    bus.ld_req_valid = 1'b0;
    bus.dc_miss      = 1'b1;
    @(negedge clk);
    chk("t5_no_done_issue", bus.ld_done_valid, 0);
    step();
    bus.dc_miss = 1'b0;
    step();
    bus.flush        = 1'b1;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_idx   = 3'd6;
    @(negedge clk);
    chk("t5_ld_ready_flush", bus.ld_req_ready, 0);
    chk("t5_busy_flush", bus.busy, 1);
    step();
    bus.flush        = 1'b0;
    bus.ld_req_valid = 1'b0;
    step();
    step();
    bus.dc_done = 1'b1;
    @(negedge clk);
    chk("t5_no_ld_done", bus.ld_done_valid, 0);
    chk("t5_busy_done", bus.busy, 1);
    step();
    bus.dc_done = 1'b0;
    @(negedge clk);
    chk("t5_busy_end", bus.busy, 0);

    // flush in IDLE with both valid: store only
    step();
    bus.flush        = 1'b1;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_idx   = 3'd1;
    bus.st_req_valid = 1'b1;
    bus.st_req_idx   = 3'd3;
    bus.st_req_data  = 32'h1234;
    @(negedge clk);
    chk("t5b_ld_ready", bus.ld_req_ready, 0);
    chk("t5b_st_ready", bus.st_req_ready, 1);
    push(1'b1, 3'd3);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t5b_write", bus.dc_req_write, 1);
    chk("t5b_data", bus.dc_req_data, 32'h1234);

    // flush while a load sits in ISSUE
    step();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_idx   = 3'd1;
    @(negedge clk);
    chk("t5c_ld_ready", bus.ld_req_ready, 1);
    step();
    bus.ld_req_valid = 1'b0;
    bus.flush        = 1'b1;
    bus.dc_miss      = 1'b1;
    @(negedge clk);
    chk("t5c_no_done", bus.ld_done_valid, 0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("t5c_valid", bus.dc_req_valid, 0);
    chk("t5c_busy", bus.busy, 0);

    // back-to-back load hits, idx wraps
    for (int i = 0; i < 9; i++) push(1'b0, 3'(i));
    stream(9, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_sb_empty", exp_q.size(), 0);

    // reset in the middle of a miss
    step();
    bus.st_req_valid = 1'b1;
    bus.st_req_idx   = 3'd7;
    bus.st_req_addr  = 32'h400;
    bus.st_req_data  = 32'h55;
    step();
    bus.st_req_valid = 1'b0;
    bus.dc_miss      = 1'b1;
    step();
    bus.dc_miss = 1'b0;
    @(negedge clk);
    chk("t1_in_miss", bus.busy, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("t1_valid", bus.dc_req_valid, 0);
    chk("t1_addr", bus.dc_req_addr, 0);
    chk("t1_data", bus.dc_req_data, 0);
    chk("t1_idx", bus.dc_req_idx, 0);
    chk("t1_write", bus.dc_req_write, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_st_done", bus.st_done_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    bus.dc_done = 1'b1;
    @(negedge clk);
    chk("t1_done_ignored", bus.st_done_valid, 0);
    chk("t1_busy_after", bus.busy, 0);
    step();
    bus.dc_done = 1'b0;
    @(negedge clk);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
